// File: rtl/alu_flag_branch_unit.sv
// NZCV flag register fed by the ALU, with same-cycle forwarding into the
// ID-stage branch evaluator and a registered branch decision for fetch.
module alu_flag_branch_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       stall,
    input  logic       flush,
    input  logic       ex_valid,
    input  logic       ex_set_flags,
    input  logic [2:0] ex_alu_op,
    input  logic       alu_negative,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry_out,
    input  logic       id_br_valid,
    input  logic [1:0] id_br_kind,
    input  logic [3:0] id_cond,
    input  logic       id_reg_zero,
    output logic [3:0] flags_q,
    output logic       br_taken_q,
    output logic       br_valid_q
);

    localparam int unsigned FLAG_W = 4;

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    localparam logic [1:0] KIND_BCOND = 2'b00;
    localparam logic [1:0] KIND_CBZ   = 2'b01;
    localparam logic [1:0] KIND_CBNZ  = 2'b10;

    logic [FLAG_W-1:0] new_flags;
    logic              src_legal;
    logic              fwd;
    logic [FLAG_W-1:0] eff_flags;
    logic              flag_n, flag_z, flag_c, flag_v;
    logic              cond_true;
    logic              br_taken_d;

    // Captured flag value per ALU op; logic ops clear C and V.
    always_comb begin
        new_flags = flags_q;
        src_legal = 1'b0;
        case (ex_alu_op)
            OP_ADD, OP_SUB: begin
                new_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
                src_legal = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                new_flags = {alu_negative, alu_zero, 2'b00};
                src_legal = 1'b1;
            end
            default: begin
                new_flags = flags_q;
                src_legal = 1'b0;
            end
        endcase
    end

    // Forwarding ignores stall so a held branch still sees the EX result.
    assign fwd       = ex_valid & ex_set_flags & ~flush & src_legal;
    assign eff_flags = fwd ? new_flags : flags_q;
    assign {flag_n, flag_z, flag_c, flag_v} = eff_flags;

    always_comb begin
        cond_true = 1'b0;
        case (id_cond)
            4'b0000: cond_true = flag_z;
            4'b0001: cond_true = ~flag_z;
            4'b0010: cond_true = flag_c;
            4'b0011: cond_true = ~flag_c;
            4'b0100: cond_true = flag_n;
            4'b0101: cond_true = ~flag_n;
            4'b0110: cond_true = flag_v;
            4'b0111: cond_true = ~flag_v;
            4'b1000: cond_true = flag_c & ~flag_z;
            4'b1001: cond_true = ~flag_c | flag_z;
            4'b1010: cond_true = (flag_n == flag_v);
            4'b1011: cond_true = (flag_n != flag_v);
            4'b1100: cond_true = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_true = flag_z | (flag_n != flag_v);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        br_taken_d = 1'b0;
        case (id_br_kind)
            KIND_BCOND: br_taken_d = id_br_valid & cond_true;
            KIND_CBZ:   br_taken_d = id_br_valid & id_reg_zero;
            KIND_CBNZ:  br_taken_d = id_br_valid & ~id_reg_zero;
            default:    br_taken_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q    <= RESET_FLAGS;
            br_taken_q <= 1'b0;
            br_valid_q <= 1'b0;
        end else begin
            if (fwd && !stall) begin
                flags_q <= new_flags;
            end
            if (flush) begin
                br_valid_q <= 1'b0;
                br_taken_q <= 1'b0;
            end else if (!stall) begin
                br_valid_q <= id_br_valid;
                br_taken_q <= br_taken_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_flag_branch_unit.sv
// Directed and randomized checks of alu_flag_branch_unit against a
// behavioural NZCV/branch model.
module tb_alu_flag_branch_unit;

    logic       clk = 1'b0;
    logic       reset_n, stall, flush;
    logic       ex_valid, ex_set_flags;
    logic [2:0] ex_alu_op;
    logic       alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic       id_br_valid;
    logic [1:0] id_br_kind;
    logic [3:0] id_cond;
    logic       id_reg_zero;
    logic [3:0] flags_q;
    logic       br_taken_q, br_valid_q;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_flags;
    logic       m_taken, m_valid;

    alu_flag_branch_unit #(.RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_set_flags(ex_set_flags), .ex_alu_op(ex_alu_op),
        .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .id_br_valid(id_br_valid), .id_br_kind(id_br_kind), .id_cond(id_cond),
        .id_reg_zero(id_reg_zero), .flags_q(flags_q),
        .br_taken_q(br_taken_q), .br_valid_q(br_valid_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Architectural condition evaluation from the flag meanings.
    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc >> 1)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return (cc % 2 == 1) ? !base : base;
    endfunction

    task automatic set_ex(input logic vld, input logic sf, input logic [2:0] op, input logic [3:0] nzcv);
        ex_valid = vld; ex_set_flags = sf; ex_alu_op = op;
        {alu_negative, alu_zero, alu_carry_out, alu_overflow} = nzcv;
    endtask

    task automatic set_id(input logic vld, input logic [1:0] kind, input logic [3:0] cc, input logic rz);
        id_br_valid = vld; id_br_kind = kind; id_cond = cc; id_reg_zero = rz;
    endtask

    // Advance the model over one clock, apply the edge, compare all outputs.
    task automatic step();
        logic [3:0] alu_f, eff;
        logic       legal, fwd, tk;
        alu_f = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        legal = (ex_alu_op >= 3'd2) && (ex_alu_op <= 3'd6);
        if (ex_alu_op >= 3'd4) alu_f[1:0] = 2'b00;
        fwd = ex_valid && ex_set_flags && !flush && legal;
        eff = fwd ? alu_f : m_flags;
        case (id_br_kind)
            2'd0: tk = cond_holds(id_cond, eff);
            2'd1: tk = id_reg_zero;
            2'd2: tk = !id_reg_zero;
            default: tk = 1'b0;
        endcase
        if (!reset_n) begin
            m_flags = 4'b0000; m_taken = 1'b0; m_valid = 1'b0;
        end else begin
            if (fwd && !stall) m_flags = alu_f;
            if (flush) begin
                m_taken = 1'b0; m_valid = 1'b0;
            end else if (!stall) begin
                m_valid = id_br_valid; m_taken = id_br_valid && tk;
            end
        end
        @(posedge clk);
        #1;
        check("flags", flags_q, m_flags);
        check("br_valid", {3'b0, br_valid_q}, {3'b0, m_valid});
        check("br_taken", {3'b0, br_taken_q}, {3'b0, m_taken});
    endtask

    initial begin
        m_flags = 4'b0000; m_taken = 1'b0; m_valid = 1'b0;
        reset_n = 1'b0; stall = 1'b1; flush = 1'b0;
        set_ex(1'b1, 1'b1, 3'b011, 4'b1111);
        set_id(1'b1, 2'd0, 4'b1110, 1'b0);
        @(negedge clk);

        // Reset held two cycles under stall
        step(); step();
        check("rst_flags", flags_q, 4'b0000);
        check("rst_valid", {3'b0, br_valid_q}, 4'd0);

        // SUBS Z=1,C=1 forwarded into B.EQ
        reset_n = 1'b1; stall = 1'b0;
        set_ex(1'b1, 1'b1, 3'b011, 4'b0110);
        set_id(1'b1, 2'd0, 4'b0000, 1'b0);
        step();
        check("fwd_eq_taken", {3'b0, br_taken_q}, 4'd1);
        check("fwd_eq_flags", flags_q, 4'b0110);

        // ANDS clears C,V; then B.LT taken, B.GE not
        set_ex(1'b1, 1'b1, 3'b100, 4'b1011);
        set_id(1'b0, 2'd0, 4'b0000, 1'b0);
        step();
        check("ands_flags", flags_q, 4'b1000);
        set_ex(1'b0, 1'b0, 3'b000, 4'b0000);
        set_id(1'b1, 2'd0, 4'b1011, 1'b0);
        step();
        check("blt_taken", {3'b0, br_taken_q}, 4'd1);
        set_id(1'b1, 2'd0, 4'b1010, 1'b0);
        step();
        check("bge_taken", {3'b0, br_taken_q}, 4'd0);

        // Stall blocks flag update and holds branch outputs
        set_ex(1'b1, 1'b1, 3'b100, 4'b0000);
        set_id(1'b1, 2'd0, 4'b1110, 1'b0);
        step();
        check("clr_flags", flags_q, 4'b0000);
        stall = 1'b1;
        set_ex(1'b1, 1'b1, 3'b011, 4'b0100);
        set_id(1'b0, 2'd0, 4'b0000, 1'b0);
        step();
        check("stall_flags", flags_q, 4'b0000);
        check("stall_hold", {2'b0, br_valid_q, br_taken_q}, 4'b0011);
        stall = 1'b0;
        step();
        check("unstall_flags", flags_q, 4'b0100);

        // B.GT on 0001 not taken; flushed CBNZ produces nothing
        set_ex(1'b1, 1'b1, 3'b010, 4'b0001);
        step();
        set_ex(1'b0, 1'b0, 3'b000, 4'b0000);
        set_id(1'b1, 2'd0, 4'b1100, 1'b0);
        step();
        check("bgt_valid", {3'b0, br_valid_q}, 4'd1);
        check("bgt_taken", {3'b0, br_taken_q}, 4'd0);
        flush = 1'b1;
        set_ex(1'b1, 1'b1, 3'b011, 4'b1111);
        set_id(1'b1, 2'd2, 4'b0000, 1'b0);
        step();
        check("flush_br", {2'b0, br_valid_q, br_taken_q}, 4'b0000);
        check("flush_flags", flags_q, 4'b0001);

        // Illegal flag source leaves flags alone
        flush = 1'b0;
        set_ex(1'b1, 1'b1, 3'b111, 4'b1111);
        set_id(1'b1, 2'd3, 4'b1110, 1'b1);
        step();
        check("illegal_op", flags_q, 4'b0001);
        check("kind11_taken", {3'b0, br_taken_q}, 4'd0);

        // Reset mid-stream beats an update and a taken branch
        set_ex(1'b1, 1'b1, 3'b011, 4'b1111);
        set_id(1'b1, 2'd1, 4'b0000, 1'b1);
        reset_n = 1'b0;
        step();
        check("midrst_flags", flags_q, 4'b0000);
        check("midrst_valid", {3'b0, br_valid_q}, 4'd0);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 31) != 0);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 7) == 0);
            set_ex(1'($urandom), 1'($urandom), 3'($urandom), 4'($urandom));
            set_id(1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
